// File: rtl/avr_uart_mmio.sv
// Memory-mapped 8N1 UART: DATA at BASE, STATUS at BASE+1.
// Ports: clock, locked (sync active-low reset), address/wb/w/rd CPU bus, dout/hit, tx, rx.
`timescale 1ns/1ps
module avr_uart_mmio #(
  parameter logic [15:0] BASE     = 16'h002C,
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        locked,
  input  logic [15:0] address,
  input  logic [7:0]  wb,
  input  logic        w,
  input  logic        rd,
  output logic [7:0]  dout,
  output logic        hit,
  output logic        tx,
  input  logic        rx
);
  localparam logic [15:0] BDIV  = 16'(BAUD_DIV);
  localparam logic [15:0] BHALF = 16'(BAUD_DIV / 2);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic w_sel_data, w_sel_stat;
  logic w_rd_data, w_wr_stat;
  assign w_sel_data = (address == BASE);
  assign w_sel_stat = (address == BASE + 16'd1);
  assign w_rd_data  = rd & w_sel_data;
  assign w_wr_stat  = w & w_sel_stat;
  assign hit        = w_sel_data | w_sel_stat;

  // TX FIFO
  logic [7:0] r_fifo [4];
  logic [1:0] r_wp, r_rp;
  logic [2:0] r_cnt;
  logic       w_push, w_pop;

  // TX FSM
  st_t        r_tx_st, w_tx_nst;
  logic [15:0] r_tx_baud;
  logic [2:0] r_tx_bit;
  logic [7:0] r_tx_sh;
  logic       r_tx, w_tx_d, w_tx_tick;
  logic       w_tx_idle, w_tx_ready;

  assign w_push     = w & w_sel_data & (r_cnt != 3'd4);
  assign w_pop      = (r_tx_st == S_IDLE) & (r_cnt != 3'd0);
  assign w_tx_tick  = (r_tx_baud == 16'd1);
  assign w_tx_ready = (r_cnt != 3'd4);
  assign w_tx_idle  = (r_cnt == 3'd0) & (r_tx_st == S_IDLE);

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wp] <= wb;
  end

  always_ff @(posedge clock) begin
    if (!locked) begin
      r_wp  <= 2'd0;
      r_rp  <= 2'd0;
      r_cnt <= 3'd0;
    end else begin
      if (w_push) r_wp <= r_wp + 2'd1;
      if (w_pop)  r_rp <= r_rp + 2'd1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 3'd1;
      else if (w_pop && !w_push) r_cnt <= r_cnt - 3'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!locked) r_tx_st <= S_IDLE;
    else         r_tx_st <= w_tx_nst;
  end

  always_comb begin
    w_tx_nst = r_tx_st;
    unique case (r_tx_st)
      S_IDLE:  if (w_pop) w_tx_nst = S_START;
      S_START: if (w_tx_tick) w_tx_nst = S_DATA;
      S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_nst = S_STOP;
      S_STOP:  if (w_tx_tick) w_tx_nst = S_IDLE;
      default: w_tx_nst = S_IDLE;
    endcase
  end

  always_comb begin
    w_tx_d = 1'b1;
    unique case (r_tx_st)
      S_START: w_tx_d = 1'b0;
      S_DATA:  w_tx_d = r_tx_sh[0];
      default: w_tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!locked) begin
      r_tx_baud <= 16'd1;
      r_tx_bit  <= 3'd0;
      r_tx_sh   <= 8'h00;
      r_tx      <= 1'b1;
    end else begin
      r_tx <= w_tx_d;
      if (r_tx_st == S_IDLE) begin
        if (w_pop) begin
          r_tx_sh   <= r_fifo[r_rp];
          r_tx_baud <= BDIV;
          r_tx_bit  <= 3'd0;
        end
      end else if (w_tx_tick) begin
        r_tx_baud <= BDIV;
        if (r_tx_st == S_DATA) begin
          r_tx_sh  <= r_tx_sh >> 1;
          r_tx_bit <= r_tx_bit + 3'd1;
        end
      end else begin
        r_tx_baud <= r_tx_baud - 16'd1;
      end
    end
  end

  assign tx = r_tx;

  // RX path
  logic       r_rx_s1, r_rx_s2, r_rx_d;
  st_t        r_rx_st, w_rx_nst;
  logic [15:0] r_rx_baud;
  logic [2:0] r_rx_bit;
  logic [7:0] r_rx_sh, r_rx_hold;
  logic       r_rx_valid, r_ovr, r_fe;
  logic       w_rx_fall, w_rx_tick, w_rx_done, w_good, w_bad;

  assign w_rx_fall = r_rx_d & ~r_rx_s2;
  assign w_rx_tick = (r_rx_baud == 16'd1);
  assign w_rx_done = (r_rx_st == S_STOP) & w_rx_tick;
  assign w_good    = w_rx_done & r_rx_s2;
  assign w_bad     = w_rx_done & ~r_rx_s2;

  always_ff @(posedge clock) begin
    if (!locked) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
    end
  end

  always_ff @(posedge clock) begin
    if (!locked) r_rx_st <= S_IDLE;
    else         r_rx_st <= w_rx_nst;
  end

  always_comb begin
    w_rx_nst = r_rx_st;
    unique case (r_rx_st)
      S_IDLE:  if (w_rx_fall) w_rx_nst = S_START;
      S_START: if (w_rx_tick) w_rx_nst = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_nst = S_STOP;
      S_STOP:  if (w_rx_tick) w_rx_nst = S_IDLE;
      default: w_rx_nst = S_IDLE;
    endcase
  end

  // First reload after the start edge is half a bit so all later ticks land mid-bit.
  always_ff @(posedge clock) begin
    if (!locked) begin
      r_rx_baud <= 16'd1;
      r_rx_bit  <= 3'd0;
      r_rx_sh   <= 8'h00;
    end else if (r_rx_st == S_IDLE) begin
      if (w_rx_fall) r_rx_baud <= BHALF;
    end else if (w_rx_tick) begin
      r_rx_baud <= BDIV;
      if (r_rx_st == S_START) r_rx_bit <= 3'd0;
      if (r_rx_st == S_DATA) begin
        r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
        r_rx_bit <= r_rx_bit + 3'd1;
      end
    end else begin
      r_rx_baud <= r_rx_baud - 16'd1;
    end
  end

  // A landing byte beats a same-cycle read clear.
  always_ff @(posedge clock) begin
    if (!locked) begin
      r_rx_hold  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_fe       <= 1'b0;
    end else begin
      if (w_good) begin
        r_rx_hold  <= r_rx_sh;
        r_rx_valid <= 1'b1;
      end else if (w_rd_data) begin
        r_rx_valid <= 1'b0;
      end
      if (w_good && r_rx_valid)    r_ovr <= 1'b1;
      else if (w_wr_stat && wb[3]) r_ovr <= 1'b0;
      if (w_bad)                   r_fe <= 1'b1;
      else if (w_wr_stat && wb[4]) r_fe <= 1'b0;
    end
  end

  always_comb begin
    dout = 8'h00;
    unique case (1'b1)
      w_sel_data: dout = r_rx_valid ? r_rx_hold : 8'h00;
      w_sel_stat: dout = {3'b000, r_fe, r_ovr, r_rx_valid,
                          w_tx_idle, w_tx_ready};
      default:    dout = 8'h00;
    endcase
  end
endmodule

// File: tb/tb_avr_uart_mmio.sv
// Self-checking bench for avr_uart_mmio: random TX/RX traffic against a
// behavioural model (byte queues, flag rules) with directed boundary cases.
`timescale 1ns/1ps
module tb_avr_uart_mmio;
  localparam int B = 8;
  localparam logic [15:0] BASE = 16'h002C;

  logic        clock = 1'b0;
  logic        locked = 1'b0;
  logic [15:0] address = 16'h0;
  logic [7:0]  wb = 8'h0;
  logic        w = 1'b0;
  logic        rd = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  dout;
  logic        hit;
  logic        tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic [7:0] exp_tx[$];

  logic [7:0] m_hold = 8'h00;
  logic m_valid = 1'b0, m_ovr = 1'b0, m_fe = 1'b0;

  avr_uart_mmio #(.BASE(BASE), .BAUD_DIV(B)) dut (
    .clock(clock), .locked(locked), .address(address), .wb(wb),
    .w(w), .rd(rd), .dout(dout), .hit(hit), .tx(tx), .rx(rx)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Bus tasks are entered and left on a falling edge.
  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    address = a; wb = d; w = 1'b1;
    @(negedge clock);
    w = 1'b0; address = 16'h0;
  endtask

  task automatic cpu_read(input logic [15:0] a, input logic r,
                          output logic [7:0] d);
    address = a; rd = r;
    #1 d = dout;
    @(negedge clock);
    rd = 1'b0; address = 16'h0;
  endtask

  function automatic logic [7:0] m_status();
    return {3'b000, m_fe, m_ovr, m_valid, 1'b1, 1'b1};
  endfunction

  task automatic chk_status(input string tag);
    logic [7:0] d;
    cpu_read(BASE + 16'd1, 1'b0, d);
    check(tag, d, m_status());
  endtask

  task automatic chk_data(input string tag);
    logic [7:0] d;
    logic [7:0] e;
    e = m_valid ? m_hold : 8'h00;
    cpu_read(BASE, 1'b1, d);
    m_valid = 1'b0;
    check(tag, d, e);
  endtask

  task automatic wr_status(input logic [7:0] v);
    cpu_write(BASE + 16'd1, v);
    if (v[3]) m_ovr = 1'b0;
    if (v[4]) m_fe = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (B) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (B) @(negedge clock);
    end
    rx = stop;
    repeat (B) @(negedge clock);
    rx = 1'b1;
    repeat (4) @(negedge clock);
    if (stop) begin
      if (m_valid) m_ovr = 1'b1;
      m_hold = b;
      m_valid = 1'b1;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic wait_tx_drain(input int budget);
    int k;
    k = 0;
    while (exp_tx.size() > 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("tx_drain", exp_tx.size(), 0);
    repeat (20) @(negedge clock);
  endtask

  // Line decoder: finds each start bit and samples every bit at its centre.
  initial begin : mon
    int ph;
    int last_start;
    int n;
    logic [7:0] sh;
    ph = -1;
    last_start = -100000;
    sh = 8'h00;
    forever begin
      @(negedge clock);
      if (!locked || !mon_en) begin
        ph = -1;
      end else if (ph < 0) begin
        if (tx == 1'b0) begin
          ph = 0;
          if (cyc - last_start < 10 * B + 8)
            check("tx_gap", cyc - last_start, 10 * B + 1);
          last_start = cyc;
        end
      end else begin
        ph++;
        if (ph == B / 2) begin
          check("tx_start", tx, 1'b0);
        end else if (ph < B / 2 + 9 * B) begin
          if ((ph - B / 2) % B == 0) sh[(ph - B / 2) / B - 1] = tx;
        end else begin
          check("tx_stop", tx, 1'b1);
          n = exp_tx.size();
          check("tx_pending", n > 0, 1'b1);
          if (n > 0) check("tx_byte", sh, exp_tx.pop_front());
          ph = -1;
        end
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic [15:0] a;
    int n, lows;
    logic [7:0] b;

    repeat (3) @(negedge clock);
    check("rst_tx", tx, 1'b1);
    locked = 1'b1;
    chk_status("rst_status");
    chk_data("rst_data");
    address = BASE;          #1 check("hit_data", hit, 1'b1);
    address = BASE + 16'd1;  #1 check("hit_stat", hit, 1'b1);
    address = BASE + 16'd2;  #1 check("hit_unmap", hit, 1'b0);
    check("dout_unmap", dout, 8'h00);
    address = 16'h0;
    @(negedge clock);

    // single byte latency and idle return
    mon_en = 1'b1;
    exp_tx.push_back(8'hA5);
    cpu_write(BASE, 8'hA5);
    check("tx_lat0", tx, 1'b1);
    @(negedge clock);
    check("tx_lat1", tx, 1'b1);
    @(negedge clock);
    check("tx_lat2", tx, 1'b0);
    repeat (78) @(negedge clock);
    cpu_read(BASE + 16'd1, 1'b0, d);
    check("busy_80", d, 8'h01);
    cpu_read(BASE + 16'd1, 1'b0, d);
    check("idle_81", d, 8'h03);
    wait_tx_drain(200);

    // FIFO full: first byte already popped, four more fill it, sixth dropped
    cpu_write(BASE, 8'h01);
    for (int i = 2; i <= 5; i++) cpu_write(BASE, 8'(i));
    cpu_read(BASE + 16'd1, 1'b0, d);
    check("full_status", d, 8'h00);
    cpu_write(BASE, 8'h06);
    cpu_read(BASE + 16'd1, 1'b0, d);
    check("full_drop", d, 8'h00);
    for (int i = 1; i <= 5; i++) exp_tx.push_back(8'(i));
    repeat (90) @(negedge clock);
    cpu_read(BASE + 16'd1, 1'b0, d);
    check("after_pop", d, 8'h01);
    wait_tx_drain(6 * 81 + 50);

    // random TX bursts
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        exp_tx.push_back(b);
        cpu_write(BASE, b);
      end
      wait_tx_drain(6 * 81 + 50);
    end

    // reset mid-frame
    mon_en = 1'b0;
    for (int i = 0; i < 3; i++) cpu_write(BASE, 8'($urandom));
    repeat (20) @(negedge clock);
    locked = 1'b0;
    @(negedge clock);
    locked = 1'b1;
    check("mid_rst_tx", tx, 1'b1);
    m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    chk_status("mid_rst_status");
    lows = 0;
    repeat (100) begin
      @(negedge clock);
      if (tx == 1'b0) lows++;
    end
    check("mid_rst_quiet", lows, 0);
    mon_en = 1'b1;

    // RX directed
    send_frame(8'h3C, 1'b1);
    chk_status("rx_3c_status");
    chk_data("rx_3c_data");
    chk_status("rx_3c_clear");
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    chk_status("ovr_status");
    chk_data("ovr_data");
    wr_status(8'h08);
    chk_status("ovr_clear");

    rx = 1'b0;
    repeat (3) @(negedge clock);
    rx = 1'b1;
    repeat (2 * B) @(negedge clock);
    chk_status("glitch");
    send_frame(8'h55, 1'b0);
    chk_status("fe_status");
    chk_data("fe_data");
    wr_status(8'h10);
    chk_status("fe_clear");

    // random RX traffic with random reads and flag clears
    for (int r = 0; r < 8; r++) begin
      send_frame(8'($urandom), ($urandom % 5) != 0);
      chk_status("rnd_status");
      if ($urandom % 2) chk_data("rnd_data");
      if ($urandom % 3 == 0) wr_status(8'($urandom));
    end
    chk_status("rnd_final");

    // random address decode
    for (int i = 0; i < 20; i++) begin
      a = ($urandom % 3 == 0) ? BASE + 16'($urandom % 3) : 16'($urandom);
      address = a;
      #1;
      check("rnd_hit", hit, (a == BASE) || (a == BASE + 16'd1));
      if (a == BASE)              check("rnd_dout", dout, m_valid ? m_hold : 8'h00);
      else if (a == BASE + 16'd1) check("rnd_dout", dout, m_status());
      else                        check("rnd_dout", dout, 8'h00);
      @(negedge clock);
    end
    address = 16'h0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
